// File: rtl/if_stage.sv
// Instruction fetch stage: drives the instruction memory request, owns the PC
// and the IF/ID pipeline register, with a one-entry buffer for words acked under stall.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;

    // Memory handshake: imem_addr is held while imem_req=1; the request completes
    // in the cycle imem_ack=1, unless redirect or halt wins that same cycle.
    assign imem_req        = (state == S_FETCH);
    assign imem_addr       = pc;
    assign pc_plus4        = pc + 32'd4;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign dbg_state       = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC & 32'hFFFF_FFFC;
            buf_instr  <= NOP_INSTR;
            buf_pc     <= 32'd0;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= 32'd0;
            ifid_pc4   <= 32'd0;
            halted     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH, S_HOLD: begin
                    if (redirect) begin
                        // Any held buffer entry becomes dead once we leave HOLD.
                        pc         <= redirect_target;
                        ifid_valid <= 1'b0;
                        ifid_instr <= NOP_INSTR;
                        state      <= S_FETCH;
                    end else if (halt) begin
                        halted     <= 1'b1;
                        ifid_valid <= 1'b0;
                        ifid_instr <= NOP_INSTR;
                        state      <= S_HALTED;
                    end else if (state == S_FETCH) begin
                        if (imem_ack && !stall) begin
                            ifid_valid <= 1'b1;
                            ifid_instr <= imem_rdata;
                            ifid_pc    <= pc;
                            ifid_pc4   <= pc_plus4;
                            pc         <= pc_plus4;
                        end else if (imem_ack) begin
                            buf_instr <= imem_rdata;
                            buf_pc    <= pc;
                            pc        <= pc_plus4;
                            state     <= S_HOLD;
                        end else if (!stall) begin
                            ifid_valid <= 1'b0;
                            ifid_instr <= NOP_INSTR;
                        end
                    end else if (!stall) begin
                        ifid_valid <= 1'b1;
                        ifid_instr <= buf_instr;
                        ifid_pc    <= buf_pc;
                        ifid_pc4   <= buf_pc + 32'd4;
                        state      <= S_FETCH;
                    end
                end
                default: state <= S_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: driver tasks issue per-cycle vectors, captured
// IF/ID contents are checked by a monitor against an expected queue.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, halt, ack;
    logic [31:0] redirect_pc, rdata;
    logic        req, ifid_valid, halted;
    logic [31:0] addr, ifid_instr, ifid_pc, ifid_pc4;
    logic [1:0]  dbg_state;

    logic        rst2, ack2;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = 32'd0;
    logic [31:0] rdata2;
    logic        req2, valid2, halted2;
    logic [31:0] addr2, instr2, pc2, pc42;
    logic [1:0]  dbg_state2;

    int checks = 0;
    int errors = 0;
    logic [95:0] exp_q[$];

    always #5 clk = ~clk;

    // Memory model: word at address A reads as A | 0x13.
    assign rdata  = addr | 32'h13;
    assign rdata2 = addr2 | 32'h13;

    if_stage dut (
        .clk(clk), .reset(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .imem_req(req), .imem_addr(addr),
        .imem_ack(ack), .imem_rdata(rdata), .ifid_valid(ifid_valid),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
        .halted(halted), .dbg_state(dbg_state)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .reset(rst2), .stall(zero1), .redirect(zero1),
        .redirect_pc(zero32), .halt(zero1), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2), .ifid_valid(valid2),
        .ifid_instr(instr2), .ifid_pc(pc2), .ifid_pc4(pc42),
        .halted(halted2), .dbg_state(dbg_state2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic a, input logic s, input logic r,
                       input logic [31:0] rp, input logic h);
        ack = a; stall = s; redirect = r; redirect_pc = rp; halt = h;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
        exp_q.push_back({instr, pc, pc4});
    endtask

    // Monitor: a new IF/ID entry is present after any edge with stall=0 and valid=1.
    always @(posedge clk) begin
        logic st;
        logic [95:0] e;
        st = stall;
        #1;
        if (!rst && !st && ifid_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected actual=%h_%h_%h required=none",
                         ifid_instr, ifid_pc, ifid_pc4);
            end else begin
                e = exp_q.pop_front();
                if ({ifid_instr, ifid_pc, ifid_pc4} !== e) begin
                    errors++;
                    $display("FAIL sb_ifid actual=%h_%h_%h required=%h_%h_%h",
                             ifid_instr, ifid_pc, ifid_pc4, e[95:64], e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rst2 = 1'b1; ack2 = 1'b0;
        ack = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", ifid_valid, 0);
        chk("rst_instr", ifid_instr, NOP);
        chk("rst_pc", ifid_pc, 0);
        chk("rst_pc4", ifid_pc4, 0);
        chk("rst_halted", halted, 0);
        chk("rst_req", req, 0);
        chk("rst_state", dbg_state, 0);
        rst = 1'b0; rst2 = 1'b0;
        #1 chk("idle_req", req, 0);
        @(negedge clk);
        chk("fetch_req", req, 1);
        chk("fetch_addr0", addr, 32'h0);

        // Back-to-back acks
        push(32'h13, 32'h0, 32'h4); cyc(1, 0, 0, 0, 0);
        chk("seq_addr4", addr, 32'h4);
        chk("seq_lag_pc", ifid_pc, 32'h0);
        push(32'h17, 32'h4, 32'h8); cyc(1, 0, 0, 0, 0);
        chk("seq_addr8", addr, 32'h8);

        // Ack under stall goes to the buffer
        cyc(1, 1, 0, 0, 0);
        chk("hold_req", req, 0);
        chk("hold_ifid_pc", ifid_pc, 32'h4);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("hold_req3", req, 0);
        push(32'h1B, 32'h8, 32'hC); cyc(0, 0, 0, 0, 0);
        chk("unhold_addr", addr, 32'hC);
        chk("unhold_req", req, 1);
        chk("unhold_instr", ifid_instr, 32'h1B);

        // No ack: keep under stall, bubble otherwise
        cyc(0, 1, 0, 0, 0);
        chk("noack_stall_valid", ifid_valid, 1);
        cyc(0, 0, 0, 0, 0);
        chk("bubble_valid", ifid_valid, 0);
        chk("bubble_instr", ifid_instr, NOP);
        chk("bubble_pc", ifid_pc, 32'h8);
        chk("bubble_pc4", ifid_pc4, 32'hC);

        // Redirect with simultaneous ack
        cyc(1, 0, 1, 32'h103, 0);
        chk("redir_addr", addr, 32'h100);
        chk("redir_valid", ifid_valid, 0);
        push(32'h113, 32'h100, 32'h104); cyc(1, 0, 0, 0, 0);
        chk("redir_next", addr, 32'h104);

        // Redirect out of HOLD drops the buffered word
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 1, 32'h200, 0);
        chk("redir_hold_addr", addr, 32'h200);
        chk("redir_hold_req", req, 1);
        cyc(0, 0, 0, 0, 0);
        push(32'h213, 32'h200, 32'h204); cyc(1, 0, 0, 0, 0);

        // Redirect beats halt
        cyc(0, 0, 1, 32'h40, 1);
        chk("rh_halted", halted, 0);
        chk("rh_addr", addr, 32'h40);
        push(32'h53, 32'h40, 32'h44); cyc(1, 0, 0, 0, 0);

        // Halt with ack, then noise
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            chk("halt_halted", halted, 1);
            chk("halt_req", req, 0);
            chk("halt_valid", ifid_valid, 0);
            chk("halt_pc", ifid_pc, 32'h40);
            chk("halt_pc4", ifid_pc4, 32'h44);
            chk("halt_addr", addr, 32'h44);
        end
        ack = 0; stall = 0; redirect = 0; halt = 0; rst = 1'b1;
        @(negedge clk);
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_addr", addr, 32'h0);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk("restart_req", req, 1);
        push(32'h13, 32'h0, 32'h4); cyc(1, 0, 0, 0, 0);

        // Reset mid-request with a late ack
        ack = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("midrst_req", req, 0);
        rst = 1'b0;
        cyc(1, 0, 0, 0, 0);
        chk("late_ack_valid", ifid_valid, 0);
        chk("late_ack_addr", addr, 32'h0);
        push(32'h13, 32'h0, 32'h4); cyc(1, 0, 0, 0, 0);
        chk("late_ack_addr4", addr, 32'h4);
        ack = 1'b0;

        // PC wrap on the second instance
        chk("wrap_addr0", addr2, 32'hFFFF_FFF8);
        ack2 = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("wrap_addr1", addr2, 32'hFFFF_FFFC);
        chk("wrap_pc4a", pc42, 32'hFFFF_FFFC);
        @(posedge clk); @(negedge clk);
        chk("wrap_addr2", addr2, 32'h0);
        chk("wrap_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc42, 32'h0);
        chk("wrap_valid", valid2, 1);
        ack2 = 1'b0;

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
